// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: owns PC/IR/register-file write
// strobes and sequences fetch, decode, execute, memory and write-back.
module multicycle_ctrl #(
    parameter logic [31:0] RESET_IR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [31:0] ir,
    input  logic        branch_taken,
    output logic        alu_a_pc,
    output logic        alu_b_imm,
    output logic [1:0]  wb_sel,
    output logic        rf_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [31:0] instret,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT_I = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic logic opcode_supported(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] ir_r;
    logic [31:0] instret_r;
    logic        illegal_r;

    logic        imem_req_s;
    logic        dmem_req_s;
    logic        dmem_we_s;
    logic        alu_a_pc_s;
    logic        alu_b_imm_s;
    logic [1:0]  wb_sel_s;
    logic        rf_we_s;
    logic        pc_we_s;
    logic [1:0]  pc_sel_s;

    logic [6:0]  opcode_s;
    logic        is_jal_s;
    logic        is_jalr_s;
    logic        is_branch_s;
    logic        is_load_s;
    logic        is_store_s;
    logic        sel_a_pc_s;
    logic        sel_b_imm_s;

    assign opcode_s    = ir_r[6:0];
    assign is_jal_s    = (opcode_s == OPC_JAL);
    assign is_jalr_s   = (opcode_s == OPC_JALR);
    assign is_branch_s = (opcode_s == OPC_BRANCH);
    assign is_load_s   = (opcode_s == OPC_LOAD);
    assign is_store_s  = (opcode_s == OPC_STORE);
    assign sel_a_pc_s  = (opcode_s == OPC_AUIPC) | is_jal_s | is_branch_s;
    assign sel_b_imm_s = ~((opcode_s == OPC_OP) | is_branch_s);

    // State, IR, retire counter and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_FETCH;
            ir_r      <= RESET_IR;
            instret_r <= 32'd0;
            illegal_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_WAIT_I && imem_rvalid) begin
                ir_r <= imem_rdata;
            end
            if (pc_we_s) begin
                instret_r <= instret_r + 32'd1;
            end
            if (state_r == ST_DECODE && !opcode_supported(opcode_s)) begin
                illegal_r <= 1'b1;
            end
        end
    end

    // Next-state and datapath strobes; operand selects stay put from EXEC to WB
    // so the ALU result (address or jump target) is stable across MEM/WB.
    always_comb begin
        state_next_s = state_r;
        imem_req_s   = 1'b0;
        dmem_req_s   = 1'b0;
        dmem_we_s    = 1'b0;
        alu_a_pc_s   = 1'b0;
        alu_b_imm_s  = 1'b0;
        wb_sel_s     = 2'd0;
        rf_we_s      = 1'b0;
        pc_we_s      = 1'b0;
        pc_sel_s     = 2'd0;
        case (state_r)
            ST_FETCH: begin
                imem_req_s   = 1'b1;
                state_next_s = ST_WAIT_I;
            end
            ST_WAIT_I: begin
                if (imem_rvalid) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_WAIT_I;
                end
            end
            ST_DECODE: begin
                if (opcode_supported(opcode_s)) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_TRAP;
                end
            end
            ST_EXEC: begin
                alu_a_pc_s  = sel_a_pc_s;
                alu_b_imm_s = sel_b_imm_s;
                if (is_branch_s) begin
                    pc_we_s      = 1'b1;
                    pc_sel_s     = branch_taken ? 2'd1 : 2'd0;
                    state_next_s = ST_FETCH;
                end else if (is_load_s || is_store_s) begin
                    state_next_s = ST_MEM;
                end else begin
                    state_next_s = ST_WB;
                end
            end
            ST_MEM: begin
                alu_a_pc_s  = sel_a_pc_s;
                alu_b_imm_s = sel_b_imm_s;
                dmem_req_s  = 1'b1;
                dmem_we_s   = is_store_s;
                if (dmem_ack) begin
                    if (is_store_s) begin
                        pc_we_s      = 1'b1;
                        state_next_s = ST_FETCH;
                    end else begin
                        state_next_s = ST_WB;
                    end
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_WB: begin
                alu_a_pc_s  = sel_a_pc_s;
                alu_b_imm_s = sel_b_imm_s;
                rf_we_s     = (ir_r[11:7] != 5'd0);
                pc_we_s     = 1'b1;
                if (is_load_s) begin
                    wb_sel_s = 2'd1;
                end else if (is_jal_s || is_jalr_s) begin
                    wb_sel_s = 2'd2;
                end else begin
                    wb_sel_s = 2'd0;
                end
                if (is_jal_s) begin
                    pc_sel_s = 2'd1;
                end else if (is_jalr_s) begin
                    pc_sel_s = 2'd2;
                end else begin
                    pc_sel_s = 2'd0;
                end
                state_next_s = ST_FETCH;
            end
            ST_TRAP: begin
                state_next_s = ST_TRAP;
            end
            default: begin
                state_next_s = ST_FETCH;
            end
        endcase
    end

    // Reset masks every strobe immediately, even when aborting mid-access.
    assign imem_req  = imem_req_s  & ~rst;
    assign dmem_req  = dmem_req_s  & ~rst;
    assign dmem_we   = dmem_we_s   & ~rst;
    assign alu_a_pc  = alu_a_pc_s  & ~rst;
    assign alu_b_imm = alu_b_imm_s & ~rst;
    assign rf_we     = rf_we_s     & ~rst;
    assign pc_we     = pc_we_s     & ~rst;
    assign wb_sel    = rst ? 2'd0 : wb_sel_s;
    assign pc_sel    = rst ? 2'd0 : pc_sel_s;

    assign ir      = ir_r;
    assign instret = instret_r;
    assign illegal = illegal_r;
    assign state   = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each instruction is expanded into a
// per-cycle expectation trace from the opcode rules and checked every cycle.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [31:0] ir;
    logic        branch_taken;
    logic        alu_a_pc;
    logic        alu_b_imm;
    logic [1:0]  wb_sel;
    logic        rf_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [31:0] instret;
    logic        illegal;
    logic [2:0]  state;

    multicycle_ctrl #(.RESET_IR(32'h00000013)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .ir(ir), .branch_taken(branch_taken),
        .alu_a_pc(alu_a_pc), .alu_b_imm(alu_b_imm), .wb_sel(wb_sel),
        .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .instret(instret), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rvalid;
        logic [31:0] rdata;
        logic        taken;
        logic        ack;
        logic [2:0]  st;
        logic        imem_req;
        logic        dmem_req;
        logic        dmem_we;
        logic        a_pc;
        logic        b_imm;
        logic [1:0]  wb_sel;
        logic        rf_we;
        logic        pc_we;
        logic [1:0]  pc_sel;
        logic [31:0] ir;
        logic [31:0] instret;
        logic        illegal;
    } cyc_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc_no   = 0;
    int          trace_len;
    int          dreq_cnt;
    logic [31:0] m_ir      = 32'h00000013;
    logic [31:0] m_instret = 32'd0;
    logic        m_illegal = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc_no, act, exp);
        end
    endtask

    function automatic bit op_known(input logic [6:0] o);
        return o inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                         7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    endfunction

    function automatic cyc_t idle(input logic [2:0] st);
        cyc_t c;
        c = '{rst: 1'b0, rvalid: 1'b0, rdata: 32'hDEADBEEF, taken: 1'b0, ack: 1'b0,
              st: st, imem_req: 1'b0, dmem_req: 1'b0, dmem_we: 1'b0, a_pc: 1'b0,
              b_imm: 1'b0, wb_sel: 2'd0, rf_we: 1'b0, pc_we: 1'b0, pc_sel: 2'd0,
              ir: m_ir, instret: m_instret, illegal: m_illegal};
        return c;
    endfunction

    // Operand selects for the instruction being executed.
    function automatic cyc_t with_ops(input cyc_t c, input logic [6:0] o);
        cyc_t r;
        r = c;
        r.a_pc  = (o == 7'b0010111) || (o == 7'b1101111) || (o == 7'b1100011);
        r.b_imm = !((o == 7'b0110011) || (o == 7'b1100011));
        return r;
    endfunction

    task automatic run_cycle(input cyc_t c, input bit chk);
        rst          = c.rst;
        imem_rvalid  = c.rvalid;
        imem_rdata   = c.rdata;
        branch_taken = c.taken;
        dmem_ack     = c.ack;
        @(negedge clk);
        if (chk) begin
            check("state",     {29'd0, state},      {29'd0, c.st});
            check("imem_req",  {31'd0, imem_req},   {31'd0, c.imem_req});
            check("dmem_req",  {31'd0, dmem_req},   {31'd0, c.dmem_req});
            check("dmem_we",   {31'd0, dmem_we},    {31'd0, c.dmem_we});
            check("alu_a_pc",  {31'd0, alu_a_pc},   {31'd0, c.a_pc});
            check("alu_b_imm", {31'd0, alu_b_imm},  {31'd0, c.b_imm});
            check("wb_sel",    {30'd0, wb_sel},     {30'd0, c.wb_sel});
            check("rf_we",     {31'd0, rf_we},      {31'd0, c.rf_we});
            check("pc_we",     {31'd0, pc_we},      {31'd0, c.pc_we});
            check("pc_sel",    {30'd0, pc_sel},     {30'd0, c.pc_sel});
            check("ir",        ir,                  c.ir);
            check("instret",   instret,             c.instret);
            check("illegal",   {31'd0, illegal},    {31'd0, c.illegal});
        end
        if (dmem_req === 1'b1) dreq_cnt++;
        trace_len++;
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    // One instruction from FETCH to the next FETCH (or into TRAP / a reset abort).
    task automatic do_instr(input logic [31:0] instr, input int iwait, input int dwait,
                            input bit taken, input bit stray, input bit abort_mem,
                            input int trap_cycles);
        cyc_t       c;
        logic [6:0] o;
        bit         ld, stq, br, jal, jalr;
        o    = instr[6:0];
        ld   = (o == 7'b0000011);
        stq  = (o == 7'b0100011);
        br   = (o == 7'b1100011);
        jal  = (o == 7'b1101111);
        jalr = (o == 7'b1100111);
        trace_len = 0;
        dreq_cnt  = 0;

        c = idle(3'd0); c.imem_req = 1'b1; c.rvalid = stray; c.ack = stray;
        run_cycle(c, 1'b1);
        for (int i = 0; i < iwait; i++) begin
            c = idle(3'd1); c.rdata = 32'hBAD00000 | i;
            run_cycle(c, 1'b1);
        end
        c = idle(3'd1); c.rvalid = 1'b1; c.rdata = instr;
        run_cycle(c, 1'b1);
        m_ir = instr;
        c = idle(3'd2); c.rvalid = 1'b1; c.rdata = 32'hFFFFFFFF;
        run_cycle(c, 1'b1);

        if (!op_known(o)) begin
            m_illegal = 1'b1;
            for (int i = 0; i < trap_cycles; i++) begin
                c = idle(3'd7); c.rvalid = 1'b1; c.ack = 1'b1; c.taken = 1'b1;
                run_cycle(c, 1'b1);
            end
            return;
        end

        c = with_ops(idle(3'd3), o); c.taken = taken;
        if (br) begin
            c.pc_we = 1'b1; c.pc_sel = taken ? 2'd1 : 2'd0;
            run_cycle(c, 1'b1);
            m_instret++;
            return;
        end
        run_cycle(c, 1'b1);

        if (ld || stq) begin
            for (int i = 0; i < dwait; i++) begin
                if (abort_mem && i == 1) begin
                    c = idle(3'd4); c.rst = 1'b1;
                    run_cycle(c, 1'b1);
                    m_ir = 32'h00000013; m_instret = 32'd0; m_illegal = 1'b0;
                    return;
                end
                c = with_ops(idle(3'd4), o); c.dmem_req = 1'b1; c.dmem_we = stq;
                run_cycle(c, 1'b1);
            end
            c = with_ops(idle(3'd4), o); c.dmem_req = 1'b1; c.dmem_we = stq; c.ack = 1'b1;
            c.pc_we = stq;
            run_cycle(c, 1'b1);
            if (stq) begin
                m_instret++;
                return;
            end
        end

        c = with_ops(idle(3'd5), o);
        c.rf_we  = (instr[11:7] != 5'd0);
        c.wb_sel = ld ? 2'd1 : ((jal || jalr) ? 2'd2 : 2'd0);
        c.pc_we  = 1'b1;
        c.pc_sel = jal ? 2'd1 : (jalr ? 2'd2 : 2'd0);
        run_cycle(c, 1'b1);
        m_instret++;
    endtask

    task automatic reset_from(input logic [2:0] cur);
        cyc_t c;
        c = idle(cur); c.rst = 1'b1;
        run_cycle(c, 1'b1);
        m_ir = 32'h00000013; m_instret = 32'd0; m_illegal = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc_no);
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc_t c;
        c = idle(3'd0); c.rst = 1'b1;
        run_cycle(c, 1'b0);
        reset_from(3'd0);

        // addi x1,x0,5
        do_instr(32'h00500093, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        check("addi_len", trace_len, 32'd5);
        check("addi_instret", instret, 32'd1);
        check("addi_next_fetch", {29'd0, state}, 32'd0);

        // lw x2,8(x1): ack on the third MEM cycle
        do_instr(32'h0080A103, 0, 2, 1'b0, 1'b0, 1'b0, 0);
        check("lw_len", trace_len, 32'd8);
        check("lw_dreq_cycles", dreq_cnt, 32'd3);

        // beq taken and not taken
        do_instr(32'h00208463, 0, 0, 1'b1, 1'b0, 1'b0, 0);
        check("beq_t_len", trace_len, 32'd4);
        do_instr(32'h00208463, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        check("beq_nt_len", trace_len, 32'd4);

        // jalr x0,0(x1)
        do_instr(32'h00008067, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        check("jalr_len", trace_len, 32'd5);

        // sw, lui, auipc, jal, add, with extra fetch waits
        do_instr(32'h0020A223, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        check("sw_len", trace_len, 32'd5);
        do_instr(32'h0020A223, 1, 1, 1'b1, 1'b0, 1'b0, 0);
        check("sw_wait_len", trace_len, 32'd7);
        do_instr(32'h123450B7, 2, 0, 1'b1, 1'b0, 1'b0, 0);
        do_instr(32'h00001117, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        do_instr(32'h008000EF, 0, 0, 1'b1, 1'b0, 1'b0, 0);
        do_instr(32'h002081B3, 1, 0, 1'b1, 1'b0, 1'b0, 0);
        do_instr(32'h00000263, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        check("instret_after_12", instret, 32'd12);

        // unsupported opcode traps until reset
        do_instr(32'h0000007F, 0, 0, 1'b0, 1'b0, 1'b0, 10);
        check("trap_illegal", {31'd0, illegal}, 32'd1);
        reset_from(3'd7);
        check("trap_cleared", {31'd0, illegal}, 32'd0);

        // reset during a pending load, then stray rvalid/ack in FETCH
        do_instr(32'h00500093, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        do_instr(32'h0080A103, 0, 3, 1'b0, 1'b0, 1'b1, 0);
        check("abort_ir", ir, 32'h00000013);
        check("abort_instret", instret, 32'd0);
        check("abort_dmem_req", {31'd0, dmem_req}, 32'd0);
        do_instr(32'h00300193, 0, 0, 1'b0, 1'b1, 1'b0, 0);
        check("post_abort_instret", instret, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
